// File: rtl/sdram_pkg.sv
// Shared types and helpers for the SDRAM command-bus responder.
package sdram_pkg;

  // Command encodings as {CS_N, RAS_N, CAS_N, WE_N}
  typedef enum logic [3:0] {
    CMD_LMR = 4'b0000,
    CMD_REF = 4'b0001,
    CMD_PRE = 4'b0010,
    CMD_ACT = 4'b0011,
    CMD_WR  = 4'b0100,
    CMD_RD  = 4'b0101,
    CMD_BST = 4'b0110,
    CMD_NOP = 4'b0111
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_BURST,
    ST_WR_BURST
  } bst_state_e;

  // Programmed mode: CAS latency (2 or 3), burst length (1,2,4,8), single-word writes
  typedef struct packed {
    logic [1:0] cl;
    logic [3:0] bl;
    logic       single_write;
  } mode_t;

  localparam mode_t MODE_RESET = '{cl: 2'd2, bl: 4'd1, single_write: 1'b0};

  // Sticky error flag positions
  localparam int ERR_CLOSED   = 0;
  localparam int ERR_ACT_OPEN = 1;
  localparam int ERR_REF_OPEN = 2;
  localparam int ERR_NO_MODE  = 3;

  function automatic logic [3:0] decode_bl(input logic [2:0] code);
    case (code)
      3'd0:    return 4'd1;
      3'd1:    return 4'd2;
      3'd2:    return 4'd4;
      3'd3:    return 4'd8;
      default: return 4'd1;
    endcase
  endfunction

  function automatic logic [1:0] decode_cl(input logic [2:0] code);
    return (code == 3'd3) ? 2'd3 : 2'd2;
  endfunction

endpackage

// File: rtl/sdram_resp_mem.sv
// Word store behind the responder: byte-maskable synchronous write, asynchronous read.
module sdram_resp_mem #(
  parameter  int ROW_W = 4,
  parameter  int COL_W = 6,
  localparam int AW    = 2 + ROW_W + COL_W
) (
  input  logic          iclk,
  input  logic [1:0]    we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   rdata
);

  logic [15:0] mem [2**AW];

  // Per-byte write; contents survive reset
  always_ff @(posedge iclk) begin
    if (we[0]) mem[waddr][7:0]  <= wdata[7:0];
    if (we[1]) mem[waddr][15:8] <= wdata[15:8];
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sdram_responder.sv
// Synthesizable stand-in for an SDRAM device: command decode, bank tracking,
// read/write burst engine and CAS-latency read pipeline over a local store.
module sdram_responder
  import sdram_pkg::*;
#(
  parameter int ROW_W = 4,
  parameter int COL_W = 6
) (
  input  logic        iclk,
  input  logic        ireset,
  input  logic        DRAM_CS_N,
  input  logic        DRAM_RAS_N,
  input  logic        DRAM_CAS_N,
  input  logic        DRAM_WE_N,
  input  logic        DRAM_CKE,
  input  logic [1:0]  DRAM_BA,
  input  logic [12:0] DRAM_ADDR,
  input  logic        DRAM_LDQM,
  input  logic        DRAM_UDQM,
  input  logic [15:0] dq_write,
  output logic [15:0] dq_read,
  output logic        odq_valid,
  output logic [3:0]  oerr,
  output logic [15:0] orefresh_count
);

  localparam int AW = 2 + ROW_W + COL_W;

  cmd_e             cmd;
  logic             cmd_open;
  logic [ROW_W-1:0] cmd_row;
  logic [AW-1:0]    cmd_addr;
  logic [3:0]       new_len;

  logic [3:0]       bank_open;
  logic [ROW_W-1:0] bank_row [4];
  mode_t            mode;
  logic             mode_loaded;

  bst_state_e       bst_state;
  logic [1:0]       bst_ba;
  logic [ROW_W-1:0] bst_row;
  logic [9:0]       bst_col;
  logic [2:0]       bst_idx;
  logic [3:0]       bst_len;
  logic             bst_ap;
  logic [9:0]       bst_col_cur;
  logic [AW-1:0]    bst_addr;
  logic             bst_last;
  logic             stop_burst;

  logic [1:0]       mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [AW-1:0]    mem_raddr;
  logic [15:0]      mem_rdata;
  logic             issue_rd;

  logic [15:0]      dq_p0, dq_p1;
  logic             vld_p0, vld_p1;

  logic             unused_ok;

  // Column of burst word idx: low log2(bl) bits count up and wrap inside the aligned block
  function automatic logic [9:0] col_at(input logic [9:0] col, input logic [2:0] idx,
                                        input logic [3:0] bl);
    logic [9:0] mask;
    mask = {6'd0, bl - 4'd1};
    return (col & ~mask) | ((col + {7'd0, idx}) & mask);
  endfunction

  // Command decode; deselect or CKE low reads as NOP
  always_comb begin
    cmd = CMD_NOP;
    if (DRAM_CKE && !DRAM_CS_N) cmd = cmd_e'({1'b0, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N});
  end

  assign cmd_open    = bank_open[DRAM_BA];
  assign cmd_row     = bank_row[DRAM_BA];
  assign cmd_addr    = {DRAM_BA, cmd_row, DRAM_ADDR[COL_W-1:0]};
  assign new_len     = (cmd == CMD_WR && mode.single_write) ? 4'd1 : mode.bl;

  assign bst_col_cur = col_at(bst_col, bst_idx, bst_len);
  assign bst_addr    = {bst_ba, bst_row, bst_col_cur[COL_W-1:0]};
  assign bst_last    = ({1'b0, bst_idx} == bst_len - 4'd1);
  assign stop_burst  = (cmd == CMD_BST) ||
                       (cmd == CMD_PRE && (DRAM_ADDR[10] || DRAM_BA == bst_ba));

  assign unused_ok   = ^{DRAM_ADDR, bst_col_cur};

  // Store access select: a new READ/WRITE takes the port, otherwise the running burst continues
  always_comb begin
    mem_we    = 2'b00;
    mem_waddr = bst_addr;
    mem_raddr = bst_addr;
    issue_rd  = 1'b0;
    if (!ireset && DRAM_CKE) begin
      if (cmd == CMD_WR && cmd_open) begin
        mem_we    = {!DRAM_UDQM, !DRAM_LDQM};
        mem_waddr = cmd_addr;
      end else if (cmd == CMD_RD && cmd_open) begin
        issue_rd  = 1'b1;
        mem_raddr = cmd_addr;
      end else if (!stop_burst) begin
        if (bst_state == ST_WR_BURST)      mem_we   = {!DRAM_UDQM, !DRAM_LDQM};
        else if (bst_state == ST_RD_BURST) issue_rd = 1'b1;
      end
    end
  end

  sdram_resp_mem #(.ROW_W(ROW_W), .COL_W(COL_W)) u_mem (
    .iclk  (iclk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (dq_write),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  // Data path registers: read pipeline words and per-bank row latches (never reset)
  always_ff @(posedge iclk) begin
    if (DRAM_CKE) begin
      // stage p0: word fetched on this edge
      dq_p0 <= mem_rdata;
      // stage p1: extra delay used for CL=3
      dq_p1 <= dq_p0;
      if (cmd == CMD_ACT) bank_row[DRAM_BA] <= DRAM_ADDR[ROW_W-1:0];
    end
  end

  // Control: mode, banks, burst FSM, read valid pipeline, error flags and refresh count
  always_ff @(posedge iclk) begin
    if (ireset) begin
      bank_open      <= '0;
      mode           <= MODE_RESET;
      mode_loaded    <= 1'b0;
      bst_state      <= ST_IDLE;
      bst_idx        <= '0;
      bst_len        <= 4'd1;
      bst_ap         <= 1'b0;
      vld_p0         <= 1'b0;
      vld_p1         <= 1'b0;
      odq_valid      <= 1'b0;
      dq_read        <= '0;
      oerr           <= '0;
      orefresh_count <= '0;
    end else if (DRAM_CKE) begin
      // stage p0/p1 valids, then output stage selected by CAS latency
      vld_p0 <= issue_rd;
      vld_p1 <= vld_p0;
      if (mode.cl == 2'd3) begin
        odq_valid <= vld_p1;
        if (vld_p1) dq_read <= dq_p1;
      end else begin
        odq_valid <= vld_p0;
        if (vld_p0) dq_read <= dq_p0;
      end

      if ((cmd == CMD_RD || cmd == CMD_WR) && cmd_open) begin
        bst_ba  <= DRAM_BA;
        bst_row <= cmd_row;
        bst_col <= DRAM_ADDR[9:0];
        bst_idx <= 3'd1;
        bst_len <= new_len;
        bst_ap  <= DRAM_ADDR[10];
        if (new_len == 4'd1) begin
          bst_state <= ST_IDLE;
          if (DRAM_ADDR[10]) bank_open[DRAM_BA] <= 1'b0;
        end else begin
          bst_state <= (cmd == CMD_RD) ? ST_RD_BURST : ST_WR_BURST;
        end
      end else if (bst_state != ST_IDLE) begin
        if (stop_burst) begin
          bst_state <= ST_IDLE;
        end else begin
          bst_idx <= bst_idx + 3'd1;
          if (bst_last) begin
            bst_state <= ST_IDLE;
            if (bst_ap) bank_open[bst_ba] <= 1'b0;
          end
        end
      end

      // Bank and mode commands come after burst close so an ACTIVE on the same edge wins
      case (cmd)
        CMD_LMR: begin
          mode        <= '{cl: decode_cl(DRAM_ADDR[6:4]), bl: decode_bl(DRAM_ADDR[2:0]),
                           single_write: DRAM_ADDR[9]};
          mode_loaded <= 1'b1;
        end
        CMD_ACT: begin
          bank_open[DRAM_BA] <= 1'b1;
          if (cmd_open) oerr[ERR_ACT_OPEN] <= 1'b1;
        end
        CMD_PRE: begin
          if (DRAM_ADDR[10]) bank_open <= '0;
          else               bank_open[DRAM_BA] <= 1'b0;
        end
        CMD_REF: begin
          orefresh_count <= orefresh_count + 16'd1;
          if (|bank_open) oerr[ERR_REF_OPEN] <= 1'b1;
        end
        CMD_RD, CMD_WR: begin
          if (!cmd_open) oerr[ERR_CLOSED] <= 1'b1;
        end
        default: ;
      endcase
      if (cmd != CMD_NOP && cmd != CMD_LMR && !mode_loaded) oerr[ERR_NO_MODE] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sdram_responder.sv
// Directed bench for sdram_responder: one linear stimulus sequence with immediate assertions.
module tb_sdram_responder;

  localparam logic [3:0] C_LMR = 4'b0000;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_NOP = 4'b0111;

  logic        iclk = 1'b0;
  logic        ireset;
  logic        DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N, DRAM_CKE;
  logic [1:0]  DRAM_BA;
  logic [12:0] DRAM_ADDR;
  logic        DRAM_LDQM, DRAM_UDQM;
  logic [15:0] dq_write;
  logic [15:0] dq_read;
  logic        odq_valid;
  logic [3:0]  oerr;
  logic [15:0] orefresh_count;

  int tests = 0;
  int fails = 0;

  logic [15:0] exp_burst [4];

  sdram_responder dut (
    .iclk           (iclk),
    .ireset         (ireset),
    .DRAM_CS_N      (DRAM_CS_N),
    .DRAM_RAS_N     (DRAM_RAS_N),
    .DRAM_CAS_N     (DRAM_CAS_N),
    .DRAM_WE_N      (DRAM_WE_N),
    .DRAM_CKE       (DRAM_CKE),
    .DRAM_BA        (DRAM_BA),
    .DRAM_ADDR      (DRAM_ADDR),
    .DRAM_LDQM      (DRAM_LDQM),
    .DRAM_UDQM      (DRAM_UDQM),
    .dq_write       (dq_write),
    .dq_read        (dq_read),
    .odq_valid      (odq_valid),
    .oerr           (oerr),
    .orefresh_count (orefresh_count)
  );

  always #5 iclk = ~iclk;

  // Drive one command cycle, then sample point is 1ns after the rising edge
  task automatic cyc(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] a,
                     input logic [15:0] d, input logic udqm, input logic cke);
    {DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N} = c;
    DRAM_BA   = ba;
    DRAM_ADDR = a;
    dq_write  = d;
    DRAM_LDQM = 1'b0;
    DRAM_UDQM = udqm;
    DRAM_CKE  = cke;
    @(posedge iclk);
    #1;
  endtask

  task automatic nop();
    cyc(C_NOP, 2'd0, 13'd0, 16'd0, 1'b0, 1'b1);
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    ireset = 1'b1;
    nop();
    nop();
    check("rst_dq", dq_read, 16'h0000);
    check("rst_vld", {15'd0, odq_valid}, 16'd0);
    check("rst_err", {12'd0, oerr}, 16'd0);
    check("rst_ref", orefresh_count, 16'd0);
    ireset = 1'b0;
    nop();

    // CL=2 BL=1 single write/read
    cyc(C_LMR, 2'd0, 13'h020, 16'h0, 1'b0, 1'b1);
    cyc(C_ACT, 2'd1, 13'h003, 16'h0, 1'b0, 1'b1);
    cyc(C_WR,  2'd1, 13'h008, 16'hA5C3, 1'b0, 1'b1);
    cyc(C_RD,  2'd1, 13'h008, 16'h0, 1'b0, 1'b1);
    check("cl2_early", {15'd0, odq_valid}, 16'd0);
    nop();
    check("cl2_vld", {15'd0, odq_valid}, 16'd1);
    check("cl2_data", dq_read, 16'hA5C3);
    nop();
    check("cl2_vld_off", {15'd0, odq_valid}, 16'd0);
    check("cl2_err", {12'd0, oerr}, 16'd0);

    // CL=3 BL=4 wrapped write burst, read from aligned start
    cyc(C_LMR, 2'd0, 13'h032, 16'h0, 1'b0, 1'b1);
    cyc(C_WR,  2'd1, 13'h00E, 16'h1111, 1'b0, 1'b1);
    cyc(C_NOP, 2'd0, 13'h000, 16'h2222, 1'b0, 1'b1);
    cyc(C_NOP, 2'd0, 13'h000, 16'h3333, 1'b0, 1'b1);
    cyc(C_NOP, 2'd0, 13'h000, 16'h4444, 1'b0, 1'b1);
    cyc(C_RD,  2'd1, 13'h00C, 16'h0, 1'b0, 1'b1);
    nop();
    check("cl3_wait", {15'd0, odq_valid}, 16'd0);
    exp_burst[0] = 16'h3333;
    exp_burst[1] = 16'h4444;
    exp_burst[2] = 16'h1111;
    exp_burst[3] = 16'h2222;
    for (int i = 0; i < 4; i++) begin
      nop();
      check($sformatf("cl3_vld%0d", i), {15'd0, odq_valid}, 16'd1);
      check($sformatf("cl3_data%0d", i), dq_read, exp_burst[i]);
    end
    nop();
    check("cl3_vld_off", {15'd0, odq_valid}, 16'd0);
    nop();

    // Upper-byte mask on an overwrite
    cyc(C_LMR, 2'd0, 13'h020, 16'h0, 1'b0, 1'b1);
    cyc(C_WR,  2'd1, 13'h020, 16'hFFFF, 1'b0, 1'b1);
    cyc(C_WR,  2'd1, 13'h020, 16'h0000, 1'b1, 1'b1);
    cyc(C_RD,  2'd1, 13'h020, 16'h0, 1'b0, 1'b1);
    nop();
    check("mask_vld", {15'd0, odq_valid}, 16'd1);
    check("mask_data", dq_read, 16'hFF00);
    nop();

    // Closed-bank read and double ACTIVE
    cyc(C_RD, 2'd2, 13'h000, 16'h0, 1'b0, 1'b1);
    check("closed_err", {12'd0, oerr}, 16'h0001);
    nop();
    check("closed_novld1", {15'd0, odq_valid}, 16'd0);
    nop();
    check("closed_novld2", {15'd0, odq_valid}, 16'd0);
    cyc(C_ACT, 2'd1, 13'h003, 16'h0, 1'b0, 1'b1);
    check("act_open_err", {12'd0, oerr}, 16'h0003);

    // Fresh reset to clear sticky flags
    ireset = 1'b1;
    nop();
    ireset = 1'b0;
    check("rst2_err", {12'd0, oerr}, 16'd0);

    // BL=8 CL=2, read with auto-precharge and a 2-cycle CKE stall
    cyc(C_LMR, 2'd0, 13'h023, 16'h0, 1'b0, 1'b1);
    cyc(C_ACT, 2'd0, 13'h005, 16'h0, 1'b0, 1'b1);
    cyc(C_WR,  2'd0, 13'h010, 16'h5A00, 1'b0, 1'b1);
    for (int i = 1; i < 8; i++) cyc(C_NOP, 2'd0, 13'h000, 16'h5A00 + 16'(i), 1'b0, 1'b1);
    cyc(C_RD, 2'd0, 13'h410, 16'h0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      nop();
      check($sformatf("bl8_vld%0d", i), {15'd0, odq_valid}, 16'd1);
      check($sformatf("bl8_data%0d", i), dq_read, 16'h5A00 + 16'(i));
      if (i == 1) begin
        for (int s = 0; s < 2; s++) begin
          cyc(C_NOP, 2'd0, 13'h000, 16'h0, 1'b0, 1'b0);
          check($sformatf("stall_vld%0d", s), {15'd0, odq_valid}, 16'd1);
          check($sformatf("stall_data%0d", s), dq_read, 16'h5A01);
        end
      end
    end
    nop();
    check("bl8_vld_off", {15'd0, odq_valid}, 16'd0);
    check("bl8_err", {12'd0, oerr}, 16'd0);
    cyc(C_RD, 2'd0, 13'h010, 16'h0, 1'b0, 1'b1);
    check("ap_closed_err", {12'd0, oerr}, 16'h0001);
    nop();
    nop();
    check("ap_novld", {15'd0, odq_valid}, 16'd0);

    // Refresh with all banks closed, then with one open
    for (int i = 0; i < 3; i++) cyc(C_REF, 2'd0, 13'h000, 16'h0, 1'b0, 1'b1);
    check("ref_count3", orefresh_count, 16'd3);
    check("ref_err_clean", {12'd0, oerr}, 16'h0001);
    cyc(C_ACT, 2'd3, 13'h000, 16'h0, 1'b0, 1'b1);
    cyc(C_REF, 2'd0, 13'h000, 16'h0, 1'b0, 1'b1);
    check("ref_count4", orefresh_count, 16'd4);
    check("ref_open_err", {12'd0, oerr}, 16'h0005);

    // Reset in the middle of a read burst
    cyc(C_ACT, 2'd0, 13'h005, 16'h0, 1'b0, 1'b1);
    cyc(C_RD,  2'd0, 13'h010, 16'h0, 1'b0, 1'b1);
    nop();
    nop();
    check("mid_vld", {15'd0, odq_valid}, 16'd1);
    check("mid_data", dq_read, 16'h5A01);
    ireset = 1'b1;
    nop();
    ireset = 1'b0;
    check("mid_rst_vld", {15'd0, odq_valid}, 16'd0);
    check("mid_rst_dq", dq_read, 16'h0000);
    check("mid_rst_err", {12'd0, oerr}, 16'd0);
    check("mid_rst_ref", orefresh_count, 16'd0);
    for (int i = 0; i < 3; i++) begin
      nop();
      check($sformatf("post_rst_vld%0d", i), {15'd0, odq_valid}, 16'd0);
    end

    // Command before LOAD MODE
    cyc(C_ACT, 2'd0, 13'h001, 16'h0, 1'b0, 1'b1);
    check("no_mode_err", {12'd0, oerr}, 16'h0008);
    nop();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
